// File: rtl/increment_decrement.sv
// Loadable up/down counter: one WIDTH-bit register, parallel load has priority over
// the count direction, and it wraps modulo 2^WIDTH in both directions.
module increment_decrement #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic             mode,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(1'b1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next-state selection: load first, otherwise step in the direction given by mode.
    always_comb begin
        count_d = count_q;
        if (ld) begin
            count_d = d_in;
        end else if (mode) begin
            count_d = count_q + STEP;
        end else begin
            count_d = count_q - STEP;
        end
    end

    // Counter register; clr clears it immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_increment_decrement.sv
// Directed bench for increment_decrement: an 8-bit and a 4-bit instance, with expected
// values written out by hand for reset, load, up and down counting, and wrap-around.
module tb_increment_decrement;

    logic       clk;
    logic       clr;
    logic       ld8;
    logic       mode8;
    logic [7:0] d8;
    logic [7:0] count8;
    logic       ld4;
    logic       mode4;
    logic [3:0] d4;
    logic [3:0] count4;

    int n_cmp;
    int n_err;

    increment_decrement #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .clr   (clr),
        .ld    (ld8),
        .mode  (mode8),
        .d_in  (d8),
        .count (count8)
    );

    increment_decrement #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .clr   (clr),
        .ld    (ld4),
        .mode  (mode4),
        .d_in  (d4),
        .count (count4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_down;
        n_cmp = 0;
        n_err = 0;
        clr   = 1'b0;
        ld8   = 1'b1;
        mode8 = 1'b1;
        d8    = 8'hA5;
        ld4   = 1'b1;
        mode4 = 1'b1;
        d4    = 4'h0;

        #2;
        chk_eq("reset8_initial", {24'h0, count8}, 32'h0000_0000);
        chk_eq("reset4_initial", {28'h0, count4}, 32'h0000_0000);
        step();
        chk_eq("reset8_ignores_ld", {24'h0, count8}, 32'h0000_0000);

        // Load 0x37, then drop clr mid-cycle.
        clr = 1'b1;
        d8  = 8'h37;
        step();
        chk_eq("load_37", {24'h0, count8}, 32'h0000_0037);
        #2;
        clr = 1'b0;
        #1;
        chk_eq("async_clear_midcycle", {24'h0, count8}, 32'h0000_0000);
        d8    = 8'h55;
        mode8 = 1'b0;
        step();
        chk_eq("held_in_reset_edge1", {24'h0, count8}, 32'h0000_0000);
        ld8 = 1'b0;
        step();
        chk_eq("held_in_reset_edge2", {24'h0, count8}, 32'h0000_0000);

        // First edge after release counts from zero.
        #2;
        clr   = 1'b1;
        mode8 = 1'b1;
        step();
        chk_eq("first_edge_after_reset", {24'h0, count8}, 32'h0000_0001);

        // Load 0x09, up twice, down ten times.
        ld8 = 1'b1;
        d8  = 8'h09;
        step();
        chk_eq("load_09", {24'h0, count8}, 32'h0000_0009);
        ld8   = 1'b0;
        mode8 = 1'b1;
        step();
        chk_eq("up_0A", {24'h0, count8}, 32'h0000_000A);
        step();
        chk_eq("up_0B", {24'h0, count8}, 32'h0000_000B);
        mode8    = 1'b0;
        exp_down = 8'h0A;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_eq($sformatf("down_%0d", i), {24'h0, count8}, {24'h0, exp_down});
            exp_down = exp_down - 8'h01;
        end

        // Upward wrap: FE -> FF -> 00 -> 01.
        ld8 = 1'b1;
        d8  = 8'hFE;
        step();
        chk_eq("load_FE", {24'h0, count8}, 32'h0000_00FE);
        ld8   = 1'b0;
        mode8 = 1'b1;
        step();
        chk_eq("wrap_up_FF", {24'h0, count8}, 32'h0000_00FF);
        step();
        chk_eq("wrap_up_00", {24'h0, count8}, 32'h0000_0000);
        step();
        chk_eq("wrap_up_01", {24'h0, count8}, 32'h0000_0001);

        // Downward wrap: 01 -> 00 -> FF -> FE.
        ld8 = 1'b1;
        d8  = 8'h01;
        step();
        chk_eq("load_01", {24'h0, count8}, 32'h0000_0001);
        ld8   = 1'b0;
        mode8 = 1'b0;
        step();
        chk_eq("wrap_dn_00", {24'h0, count8}, 32'h0000_0000);
        step();
        chk_eq("wrap_dn_FF", {24'h0, count8}, 32'h0000_00FF);
        step();
        chk_eq("wrap_dn_FE", {24'h0, count8}, 32'h0000_00FE);

        // Load beats mode in both directions.
        ld8 = 1'b1;
        d8  = 8'h20;
        step();
        chk_eq("load_20", {24'h0, count8}, 32'h0000_0020);
        mode8 = 1'b1;
        d8    = 8'h80;
        step();
        chk_eq("load_priority_up", {24'h0, count8}, 32'h0000_0080);
        mode8 = 1'b0;
        d8    = 8'h3C;
        step();
        chk_eq("load_priority_dn", {24'h0, count8}, 32'h0000_003C);

        // Narrow instance: F -> 0 going up, 0 -> F -> E going down.
        ld4 = 1'b1;
        d4  = 4'hF;
        step();
        chk_eq("w4_load_F", {28'h0, count4}, 32'h0000_000F);
        ld4   = 1'b0;
        mode4 = 1'b1;
        step();
        chk_eq("w4_wrap_up_0", {28'h0, count4}, 32'h0000_0000);
        mode4 = 1'b0;
        step();
        chk_eq("w4_wrap_dn_F", {28'h0, count4}, 32'h0000_000F);
        step();
        chk_eq("w4_dn_E", {28'h0, count4}, 32'h0000_000E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/increment_decrement.md
INCREMENT_DECREMENT -- requirements
Module: increment_decrement

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bit width of d_in and count.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port ld, input, 1 bit: synchronous parallel-load request, active-high.
REQ-005 The block SHALL have port mode, input, 1 bit: count direction, 1 = increment, 0 = decrement.
REQ-006 The block SHALL have port d_in, input, WIDTH bits: load value.
REQ-007 The block SHALL have port count, output, WIDTH bits: current counter value, driven directly from a register.

Function
REQ-008 The block SHALL take exactly one action on each rising clk edge while clr is high, chosen by the priority order in REQ-009 to REQ-011.
REQ-009 Load: if ld = 1, count SHALL become d_in on that edge, regardless of mode.
REQ-010 Increment: if ld = 0 and mode = 1, count SHALL become count + 1, modulo 2^WIDTH.
REQ-011 Decrement: if ld = 0 and mode = 0, count SHALL become count - 1, modulo 2^WIDTH.
REQ-012 Latency SHALL be one cycle: the new count value is visible right after the active edge, with no combinational path from any input to count.
REQ-013 Increment wrap-around: incrementing all-ones SHALL give 0.
REQ-014 Decrement wrap-around: decrementing 0 SHALL give all-ones.
REQ-015 No flags or saturation SHALL be produced at either wrap-around.
REQ-016 The block SHALL have no hold state: with ld = 0 the counter changes on every edge.
REQ-017 An X or Z value on ld or mode is not a legal input; behaviour under such values SHALL NOT be required.

Reset
REQ-018 While clr = 0, count SHALL be 0 immediately, independent of clk.
REQ-019 While clr = 0, count SHALL stay 0 and ignore ld, mode and d_in.
REQ-020 Reset asserted in the middle of counting SHALL clear count without waiting for a clock edge.
REQ-021 On the first rising edge after clr deasserts, the block SHALL apply REQ-009 to REQ-011 starting from 0.
REQ-022 The reset SHALL be the only asynchronous control; ld SHALL act only on clock edges.

Structure
REQ-023 The block SHALL be a single module containing one WIDTH-bit register and its next-state logic.
REQ-024 No shared package SHALL be required; WIDTH SHALL stay a module parameter.
REQ-025 No sub-module SHALL be instantiated.
REQ-026 The next-state selection SHALL be written as one prioritised decision: reset, then ld, then mode.

Verification
REQ-027 Reset: drive clr = 0 mid-cycle with count = 0x37 -> count = 0x00 before the next clk edge; it stays 0 across edges while clr = 0.
REQ-028 Load then count up and down: clr = 1, ld = 1, d_in = 0x09 for one edge -> count = 0x09; then ld = 0, mode = 1 for two edges -> 0x0A, 0x0B; then mode = 0 for ten edges -> 0x0A down to 0x01.
REQ-029 Upward wrap: load 0xFE, then mode = 1 for three edges -> 0xFF, 0x00, 0x01.
REQ-030 Downward wrap: load 0x01, then mode = 0 for three edges -> 0x00, 0xFF, 0xFE.
REQ-031 Load priority: count = 0x20, ld = 1, mode = 1, d_in = 0x80 -> count = 0x80, not 0x21.
REQ-032 Every scenario SHALL be checked against a cycle-accurate reference model; a WIDTH = 4 build SHALL pass the wrap-around cases (0xF -> 0x0 and 0x0 -> 0xF).
